write_to_imem: RTL

Loader-side counterpart of the instruction-memory read path: a 32-entry × 32-bit instruction store that is filled over a byte-serial valid/ready stream and read through a combinational fetch port. A small FSM assembles four little-endian bytes per instruction and writes them at incrementing word addresses. The read port keeps the fetch contract: out-of-range address returns all ones. The block sits between the boot/debug loader and instruction fetch.

---
 rtl/write_to_imem.sv | 121 ++++++++++++
 1 files changed

// File: rtl/write_to_imem.sv
`default_nettype none
// ============================================================================
// write_to_imem: 32x32 instruction store filled by a byte-serial loader,
// read through a combinational fetch port. Rev 1.0
// ============================================================================
module write_to_imem #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic [63:0]       rd_addr,
  output logic [31:0]       rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];

  logic        accept;
  logic        wr_en;
  logic [31:0] wr_word;

  assign byte_ready = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign load_done  = (state_q == S_DONE);
  assign load_count = count_q;
  assign accept     = byte_ready & byte_valid;
  assign wr_word    = {byte_data, asm_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          lane_d  = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            wr_en   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            lane_d  = '0;
            if (ptr_q == LAST_PTR) state_d = S_DONE;
          end else begin
            case (lane_q)
              2'd0:    asm_d[7:0]   = byte_data;
              2'd1:    asm_d[15:8]  = byte_data;
              default: asm_d[23:16] = byte_data;
            endcase
            lane_d = lane_q + 1'b1;
          end
        end
        // An early end drops any partially assembled word.
        if (load_end) begin
          state_d = S_DONE;
          lane_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem_d[i] = (wr_en && (ptr_q == ADDR_W'(i))) ? wr_word : mem_q[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q[i] <= '0;
      else        mem_q[i] <= mem_d[i];
    end
  end

  // Any address bit above the word index marks the fetch as out of range.
  assign rd_data = (|rd_addr[63:ADDR_W]) ? 32'hFFFF_FFFF : mem_q[rd_addr[ADDR_W-1:0]];

endmodule
`default_nettype wire
